// File: rtl/pu_or1k_wb_arbiter_pkg.sv
// Shared types, cycle-type constants and the round-robin pick function for the
// OR1K processing-unit Wishbone arbiter.
package pu_or1k_wb_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned PTR_W       = 3;

    // One-hot pick of the first requester at or after ptr, wrapping modulo n.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [PTR_W-1:0]       ptr,
        input int unsigned            n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        int unsigned            idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (i < n) begin
                idx = (32'(ptr) + i) % n;
                if (!found && req[idx[PTR_W-1:0]]) begin
                    gnt[idx[PTR_W-1:0]] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/pu_or1k_wb_arbiter_if.sv
// Bus bundle around the arbiter: NUM_MASTERS flattened master ports plus one slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface pu_or1k_wb_arbiter_if #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned NUM_MASTERS = 3
);
    logic [NUM_MASTERS*AW-1:0] wbm_adr_i;
    logic [NUM_MASTERS*DW-1:0] wbm_dat_i;
    logic [NUM_MASTERS*4-1:0]  wbm_sel_i;
    logic [NUM_MASTERS-1:0]    wbm_we_i;
    logic [NUM_MASTERS-1:0]    wbm_cyc_i;
    logic [NUM_MASTERS-1:0]    wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
    logic [DW-1:0]             wbm_dat_o;
    logic [NUM_MASTERS-1:0]    wbm_ack_o;
    logic [NUM_MASTERS-1:0]    wbm_err_o;
    logic [NUM_MASTERS-1:0]    wbm_rty_o;

    logic [AW-1:0]             wbs_adr_o;
    logic [DW-1:0]             wbs_dat_o;
    logic [3:0]                wbs_sel_o;
    logic                      wbs_we_o;
    logic                      wbs_cyc_o;
    logic                      wbs_stb_o;
    logic [2:0]                wbs_cti_o;
    logic [1:0]                wbs_bte_o;
    logic [DW-1:0]             wbs_dat_i;
    logic                      wbs_ack_i;
    logic                      wbs_err_i;
    logic                      wbs_rty_i;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
               wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
               wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
               wbs_cti_o, wbs_bte_o
    );
endinterface

// File: rtl/pu_or1k_rr_picker.sv
// Combinational round-robin selector: one-hot gnt of the first req bit at or after ptr.
module pu_or1k_rr_picker
    import pu_or1k_wb_arbiter_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [MAX_MASTERS-1:0] pick;
    logic                   unused_pick;

    always_comb begin
        pick = rr_pick(MAX_MASTERS'(req), PTR_W'(ptr), N);
        gnt  = pick[N-1:0];
    end

    // Upper pick bits are always zero for N < MAX_MASTERS.
    assign unused_pick = ^pick;
endmodule

// File: rtl/pu_or1k_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter with cycle locking, sharing one slave among NUM_MASTERS.
// Optional slave no-response timeout: define PU_OR1K_WB_ARBITER_TIMEOUT_EN.
module pu_or1k_wb_arbiter
    import pu_or1k_wb_arbiter_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    pu_or1k_wb_arbiter_if.slave    bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   busy_o
);
    localparam int unsigned N  = NUM_MASTERS;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   pick;
    logic [PW-1:0]  gidx;
    logic           g_cyc, g_stb;
    logic           tmo_fire;

    pu_or1k_rr_picker #(.N(N), .PW(PW)) u_picker (
        .req (bus.wbm_cyc_i),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) gidx = PW'(i);
        end
        g_cyc = |(bus.wbm_cyc_i & grant_q);
        g_stb = |(bus.wbm_stb_i & grant_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant is taken in IDLE and held until the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|bus.wbm_cyc_i) begin
                    state_d = OWNED;
                    grant_d = pick;
                end
            end
            OWNED: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave side is a gated mux of the owner; responses go back to the owner only.
    always_comb begin
        logic          active;
        logic [AW-1:0] m_adr;
        logic [DW-1:0] m_dat;
        logic [3:0]    m_sel;
        logic          m_we;
        logic [2:0]    m_cti;
        logic [1:0]    m_bte;
        m_adr = '0;
        m_dat = '0;
        m_sel = '0;
        m_we  = 1'b0;
        m_cti = CLASSIC;
        m_bte = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                m_adr = bus.wbm_adr_i[i*AW +: AW];
                m_dat = bus.wbm_dat_i[i*DW +: DW];
                m_sel = bus.wbm_sel_i[i*4 +: 4];
                m_we  = bus.wbm_we_i[i];
                m_cti = bus.wbm_cti_i[i*3 +: 3];
                m_bte = bus.wbm_bte_i[i*2 +: 2];
            end
        end
        active        = (state_q == OWNED) && g_cyc && !tmo_fire;
        bus.wbs_cyc_o = active;
        bus.wbs_stb_o = active && g_stb;
        bus.wbs_we_o  = active && m_we;
        bus.wbs_adr_o = active ? m_adr : '0;
        bus.wbs_dat_o = active ? m_dat : '0;
        bus.wbs_sel_o = active ? m_sel : '0;
        bus.wbs_cti_o = active ? m_cti : CLASSIC;
        bus.wbs_bte_o = active ? m_bte : '0;
        bus.wbm_dat_o = bus.wbs_dat_i;
        bus.wbm_ack_o = grant_q & {N{active && bus.wbs_ack_i}};
        bus.wbm_err_o = grant_q & {N{(active && bus.wbs_err_i) || tmo_fire}};
        bus.wbm_rty_o = grant_q & {N{active && bus.wbs_rty_i}};
        grant_o       = grant_q;
        busy_o        = (state_q == OWNED);
    end

`ifdef PU_OR1K_WB_ARBITER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt_q;
    logic          raw_stb, resp;

    assign raw_stb  = (state_q == OWNED) && g_cyc && g_stb;
    assign resp     = bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i;
    assign tmo_fire = raw_stb && !resp && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Counts strobed cycles the slave leaves unanswered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q != OWNED || !g_cyc || resp || tmo_fire) begin
            tmo_cnt_q <= '0;
        end else if (g_stb) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    assign tmo_fire = 1'b0;
`endif

endmodule

// File: tb/tb_pu_or1k_wb_arbiter.sv
// Scoreboard bench for pu_or1k_wb_arbiter: expected acks and grant order are queued
// as stimulus is issued and popped when the arbiter responds.
module tb_pu_or1k_wb_arbiter;
    import pu_or1k_wb_arbiter_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned NM  = 3;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pu_or1k_wb_arbiter_if #(.AW(AW), .DW(DW), .NUM_MASTERS(NM)) bus ();
    logic [NM-1:0] grant;
    logic          busy;

    pu_or1k_wb_arbiter #(
        .AW(AW), .DW(DW), .NUM_MASTERS(NM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .grant_o  (grant),
        .busy_o   (busy)
    );

    typedef struct packed {
        logic [NM-1:0] ack;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
        logic          we;
    } exp_t;

    exp_t          exp_q[$];
    logic [NM-1:0] gnt_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    bit            slave_on = 1'b1;
    bit            late_ack = 1'b0;
    int            lat      = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [2:0] beat_cti(input int beats, input int b);
        if (beats == 1) return CLASSIC;
        return (b == beats - 1) ? EOB : INCR;
    endfunction

    // Slave memory model: acks lat cycles after seeing a strobe, one beat at a time.
    initial begin
        int wcnt;
        wcnt          = 0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;
        bus.wbs_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.wbs_ack_i) begin
                bus.wbs_ack_i = 1'b0;
            end else if (late_ack) begin
                bus.wbs_ack_i = 1'b1;
            end else if (!slave_on) begin
                wcnt = 0;
            end else if (bus.wbs_cyc_o && bus.wbs_stb_o) begin
                if (wcnt >= lat) begin
                    bus.wbs_ack_i = 1'b1;
                    bus.wbs_dat_i = rd_data(bus.wbs_adr_o);
                    wcnt          = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic m_drive(input int k, input logic [31:0] a, input logic [2:0] cti,
                           input logic we, input logic cyc);
        bus.wbm_cyc_i[k]          = cyc;
        bus.wbm_stb_i[k]          = cyc;
        bus.wbm_we_i[k]           = we;
        bus.wbm_adr_i[k*AW +: AW] = a;
        bus.wbm_dat_i[k*DW +: DW] = ~a;
        bus.wbm_sel_i[k*4 +: 4]   = 4'hF;
        bus.wbm_cti_i[k*3 +: 3]   = cti;
        bus.wbm_bte_i[k*2 +: 2]   = 2'b00;
    endtask

    task automatic m_wait_ack(input int k, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.wbm_ack_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("ack_wait_m%0d", k), 32'd0, 32'd1);
    endtask

    task automatic m_xfer(input int k, input logic [31:0] a, input int beats, input logic we);
        bit ok;
        for (int b = 0; b < beats; b++) begin
            m_drive(k, a + 32'(4 * b), beat_cti(beats, b), we, 1'b1);
            m_wait_ack(k, ok);
            @(posedge clk);
            #1;
            if (!ok) break;
        end
        m_drive(k, 32'h0, CLASSIC, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input int k, input logic [31:0] a, input int beats, input logic we);
        exp_t e;
        for (int b = 0; b < beats; b++) begin
            e.ack = NM'(1) << k;
            e.dat = rd_data(a + 32'(4 * b));
            e.cti = beat_cti(beats, b);
            e.we  = we;
            exp_q.push_back(e);
        end
    endtask

    task automatic gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_we_i  = '0;
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;
        rst = 1'b1;
        fork
            begin : monitor
                logic [NM-1:0] prev;
                exp_t          e;
                prev = '0;
                forever begin
                    @(negedge clk);
                    if (|bus.wbm_ack_o) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_ack", 32'(bus.wbm_ack_o), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("ack_route", 32'(bus.wbm_ack_o), 32'(e.ack));
                            check("rd_data", bus.wbm_dat_o, e.dat);
                            check("cti_pass", 32'(bus.wbs_cti_o), 32'(e.cti));
                            check("we_pass", 32'(bus.wbs_we_o), 32'(e.we));
                        end
                    end
                    if (grant != prev) begin
                        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                        check("idle_gap", 32'(prev != '0 && grant != '0), 32'd0);
                        if (grant != '0) begin
                            if (gnt_q.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
                            else check("grant_order", 32'(grant), 32'(gnt_q.pop_front()));
                        end
                        prev = grant;
                    end
                end
            end
            begin : main
                bit ok;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_grant", 32'(grant), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_cyc", 32'(bus.wbs_cyc_o), 32'd0);
                check("rst_stb", 32'(bus.wbs_stb_o), 32'd0);
                check("rst_we", 32'(bus.wbs_we_o), 32'd0);
                check("rst_ack", 32'(bus.wbm_ack_o), 32'd0);
                gap();

                // All three request together; m0 re-requests after its first access.
                push_exp(0, 32'h1000, 1, 1'b0);
                push_exp(1, 32'h2000, 1, 1'b0);
                push_exp(2, 32'h3000, 1, 1'b1);
                push_exp(0, 32'h1004, 1, 1'b0);
                gnt_q.push_back(3'b001);
                gnt_q.push_back(3'b010);
                gnt_q.push_back(3'b100);
                gnt_q.push_back(3'b001);
                fork
                    begin
                        m_xfer(0, 32'h1000, 1, 1'b0);
                        @(posedge clk);
                        #1;
                        m_xfer(0, 32'h1004, 1, 1'b0);
                    end
                    m_xfer(1, 32'h2000, 1, 1'b0);
                    m_xfer(2, 32'h3000, 1, 1'b1);
                join
                gap();

                // m1 burst holds the bus against a waiting m0.
                push_exp(1, 32'h4000, 4, 1'b0);
                push_exp(0, 32'h5000, 1, 1'b0);
                gnt_q.push_back(3'b010);
                gnt_q.push_back(3'b001);
                fork
                    m_xfer(1, 32'h4000, 4, 1'b0);
                    begin
                        @(posedge clk);
                        #1;
                        m_xfer(0, 32'h5000, 1, 1'b0);
                    end
                join
                gap();

                // Single master: one-cycle arbitration latency and release.
                push_exp(0, 32'h0100, 1, 1'b0);
                gnt_q.push_back(3'b001);
                m_drive(0, 32'h0100, CLASSIC, 1'b0, 1'b1);
                @(negedge clk);
                check("arb_lat_req_cycle", 32'(bus.wbs_cyc_o), 32'd0);
                @(negedge clk);
                check("arb_lat_next_cycle", 32'(bus.wbs_cyc_o), 32'd1);
                check("single_grant", 32'(grant), 32'd1);
                m_wait_ack(0, ok);
                @(posedge clk);
                #1;
                m_drive(0, 32'h0, CLASSIC, 1'b0, 1'b0);
                @(negedge clk);
                check("release_gated", 32'(bus.wbs_cyc_o), 32'd0);
                @(negedge clk);
                check("release_grant", 32'(grant), 32'd0);
                gap();

                // Abort: cyc dropped before the slave answers; the late ack is discarded.
                slave_on = 1'b0;
                gnt_q.push_back(3'b001);
                m_drive(0, 32'h0200, CLASSIC, 1'b0, 1'b1);
                repeat (2) @(posedge clk);
                #1;
                m_drive(0, 32'h0, CLASSIC, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                late_ack = 1'b1;
                @(negedge clk);
                check("abort_ack", 32'(bus.wbm_ack_o), 32'd0);
                @(posedge clk);
                #1;
                late_ack = 1'b0;
                slave_on = 1'b1;
                gap();

                // Reset during beat 2 of an m2 burst.
                push_exp(2, 32'h6000, 1, 1'b0);
                exp_q[exp_q.size()-1].cti = INCR;
                gnt_q.push_back(3'b100);
                m_drive(2, 32'h6000, INCR, 1'b0, 1'b1);
                m_wait_ack(2, ok);
                @(posedge clk);
                #1;
                m_drive(2, 32'h6004, INCR, 1'b0, 1'b1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                m_drive(2, 32'h0, CLASSIC, 1'b0, 1'b0);
                @(negedge clk);
                check("midrst_cyc", 32'(bus.wbs_cyc_o), 32'd0);
                check("midrst_grant", 32'(grant), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                gap();

                // Pointer back at 0 after reset: m0 wins over m1.
                push_exp(0, 32'h7000, 1, 1'b0);
                push_exp(1, 32'h7100, 1, 1'b0);
                gnt_q.push_back(3'b001);
                gnt_q.push_back(3'b010);
                fork
                    m_xfer(0, 32'h7000, 1, 1'b0);
                    m_xfer(1, 32'h7100, 1, 1'b0);
                join
                gap();

`ifdef PU_OR1K_WB_ARBITER_TIMEOUT_EN
                begin
                    int n;
                    bit hit;
                    slave_on = 1'b0;
                    gnt_q.push_back(3'b001);
                    m_drive(0, 32'h8000, CLASSIC, 1'b0, 1'b1);
                    n   = 0;
                    hit = 1'b0;
                    for (int c = 0; c < 100; c++) begin
                        @(negedge clk);
                        if (busy) n++;
                        if (|bus.wbm_err_o) begin
                            hit = 1'b1;
                            break;
                        end
                    end
                    check("tmo_hit", 32'(hit), 32'd1);
                    check("tmo_cycle", 32'(n), 32'(TMO));
                    check("tmo_err", 32'(bus.wbm_err_o), 32'd1);
                    check("tmo_cyc_gated", 32'(bus.wbs_cyc_o), 32'd0);
                    @(negedge clk);
                    check("tmo_err_pulse", 32'(bus.wbm_err_o), 32'd0);
                    check("tmo_restrobe", 32'(bus.wbs_stb_o), 32'd1);
                    @(posedge clk);
                    #1;
                    m_drive(0, 32'h0, CLASSIC, 1'b0, 1'b0);
                    slave_on = 1'b1;
                    gap();
                end
`endif

                check("exp_q_drained", 32'(exp_q.size()), 32'd0);
                check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench did not finish");
    end
endmodule

// File: doc/pu_or1k_wb_arbiter.md
Name: pu_or1k_wb_arbiter

Overview:
Shares one Wishbone B3 slave port, such as the main RAM, between NUM_MASTERS masters. In the PU these are the OR1K data bus, the OR1K instruction bus and the debug master.
- Arbitration is round-robin with bus locking: the owner holds the slave for its whole cycle (cyc high), including incrementing or wrapping bursts.
- The block sits between the processing-unit masters and the memory slave, in place of a fixed-priority mux.

Parameters:
AW, 32, address width
DW, 32, data width
NUM_MASTERS, 3, number of requesting masters (2..8); index 0 = or1k_d, 1 = or1k_i, 2 = dbg
TIMEOUT_CYCLES, 256, slave no-response limit in cycles; used only with the optional feature

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, synchronous, active-high
wbm_adr_i  in  NUM_MASTERS*AW  master addresses, flattened, master k at [k*AW +: AW]
wbm_dat_i  in  NUM_MASTERS*DW  master write data
wbm_sel_i  in  NUM_MASTERS*4  byte selects
wbm_we_i  in  NUM_MASTERS  write enables
wbm_cyc_i  in  NUM_MASTERS  cycle requests
wbm_stb_i  in  NUM_MASTERS  strobes
wbm_cti_i  in  NUM_MASTERS*3  cycle type identifiers
wbm_bte_i  in  NUM_MASTERS*2  burst type extensions
wbm_dat_o  out  DW  read data, broadcast to all masters
wbm_ack_o  out  NUM_MASTERS  per-master ack
wbm_err_o  out  NUM_MASTERS  per-master err
wbm_rty_o  out  NUM_MASTERS  per-master rty
wbs_adr_o  out  AW  slave address
wbs_dat_o  out  DW  slave write data
wbs_sel_o  out  4  slave byte selects
wbs_we_o  out  1  slave write enable
wbs_cyc_o  out  1  slave cycle
wbs_stb_o  out  1  slave strobe
wbs_cti_o  out  3  slave cycle type
wbs_bte_o  out  2  slave burst type
wbs_dat_i  in  DW  slave read data
wbs_ack_i  in  1  slave ack
wbs_err_i  in  1  slave err
wbs_rty_i  in  1  slave rty
grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
busy_o  out  1  high while in the OWNED state

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge):
  - state=IDLE, grant=0, rr_ptr=0.
  - All slave control outputs (cyc, stb, we) are 0; ack/err/rty to all masters are 0; grant_o=0, busy_o=0.
  - Reset mid-transfer drops wbs_cyc_o in the cycle after the edge; no response is forwarded.
- IDLE state:
  - Slave outputs are gated to 0.
  - If any wbm_cyc_i is set, pick the first requester at or after rr_ptr, searching upward modulo NUM_MASTERS.
  - Register that master as the one-hot grant and move to OWNED.
  - Arbitration latency is exactly one cycle: request at cycle N, wbs_cyc_o at N+1.
- OWNED state:
  - Slave outputs are a combinational mux of the granted master's signals: wbs_cyc_o = wbm_cyc_i[g], wbs_stb_o = wbm_stb_i[g] & wbm_cyc_i[g].
  - wbs_ack_i, wbs_err_i and wbs_rty_i route only to bit g; all other masters see 0.
  - wbm_dat_o = wbs_dat_i at all times.
- Release:
  - When wbm_cyc_i[g]=0, go to IDLE with rr_ptr = (g+1) mod NUM_MASTERS. That cycle's slave outputs are already gated off.
  - There is no re-arbitration in the same cycle: minimum one IDLE cycle between owners.
- Bursts: cti and bte pass through unchanged. The grant never changes while cyc is held, including the cti=3'b111 end-of-burst beat, so an owner that keeps cyc high retains the bus.
- Simultaneous requests: the round-robin order guarantees each continuously requesting master gets the bus within NUM_MASTERS grants.
- A master dropping cyc while the slave still owes an ack (abort): release occurs; any late slave ack after the release is discarded.
- Grant is never 0 in OWNED, and never more than one bit is set.

Optional Feature:
Macro: PU_OR1K_WB_ARBITER_TIMEOUT_EN.
- Enabled: a counter of width $clog2(TIMEOUT_CYCLES)+1 increments each OWNED cycle with wbs_stb_o=1 and no ack, err or rty from the slave.
  - The counter clears on any response, on release and on reset.
  - When the count equals TIMEOUT_CYCLES-1, the arbiter asserts wbm_err_o[g] for one cycle.
  - In that same cycle it forces wbs_cyc_o/wbs_stb_o to 0, then clears the counter.
- Disabled: no counter; err is pure pass-through, and a hung slave stalls its owner indefinitely.

Decomposition:
- Package pu_or1k_wb_arbiter_pkg:
  - state enum {IDLE, OWNED};
  - CTI constants CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111;
  - a function returning the one-hot round-robin pick from a request vector and a pointer.
- One sub-module, pu_or1k_rr_picker: combinational round-robin selector, taking req and ptr and producing a one-hot gnt.

Test Plan:
- Single master: m0 reads 0x100 and the slave acks at the 2nd cycle after stb -> wbs_cyc_o rises 1 cycle after wbm_cyc_i[0]; wbm_ack_o=3'b001; grant_o=3'b001 then 0.
- Simultaneous request: cyc=3'b111 held, each master doing one classic access -> grants in order 001, 010, 100, 001 with exactly one IDLE cycle between each.
- Burst lock: m1 does a 4-beat incrementing burst (cti 010,010,010,111) while m0 requests -> m0 receives no grant until m1 drops cyc after the 4th ack.
- Reset mid-burst: wb_rst_i=1 on beat 2 of an m2 burst -> next cycle wbs_cyc_o=0, grant_o=0, busy_o=0, rr_ptr=0.
- Abort: m0 drops cyc before ack and the slave acks 1 cycle later -> wbm_ack_o stays 3'b000.
- Timeout (macro defined, TIMEOUT_CYCLES=16): the slave never acks -> wbm_err_o[g] pulses at the 16th stb cycle, wbs_cyc_o=0 in that cycle, counter resets.
